// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core run-control / register-watch monitor.
package rv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CNT_W     = 32;

  typedef enum logic [1:0] {
    RW_RUN     = 2'd0,
    RW_HALT    = 2'd1,
    RW_TIMEOUT = 2'd2
  } rw_state_e;

endpackage

// File: rtl/rv_halt_detect.sv
// PC-stuck detector: counts consecutive cycles with an unchanged fetch PC and
// flags the edge on which the stable run reaches HALT_REPEAT-1.
module rv_halt_detect
  import rv_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_q,
  output logic            halt_hit
);

  logic [CNT_W-1:0] stable_cnt;
  logic             armed_q;
  logic             same;

  // The first enabled cycle after reset has no valid pc_q to compare against.
  assign same     = armed_q && (pc == pc_q);
  assign halt_hit = en && same && (stable_cnt == CNT_W'(HALT_REPEAT - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      stable_cnt <= '0;
      armed_q    <= 1'b0;
    end else if (en) begin
      pc_q       <= pc;
      armed_q    <= 1'b1;
      stable_cnt <= same ? stable_cnt + CNT_W'(1) : '0;
    end
  end

endmodule

// File: rtl/rv_regwatch_monitor.sv
// Run-control and register-watch monitor for the 3-stage RISC-V core.
// Optional simulation trace: define RV_REGWATCH_TRACE_EN.
module rv_regwatch_monitor
  import rv_pkg::*;
#(
  parameter  int unsigned XLEN        = XLEN_DEF,
  parameter  int unsigned NUM_WATCH   = 3,
  parameter  int unsigned WATCH_BASE  = 1,
  parameter  int unsigned MAX_CYCLES  = 1024,
  parameter  int unsigned HALT_REPEAT = 4,
  localparam int unsigned IDX_W       = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XLEN-1:0]           pc,
  input  logic                      rf_we,
  input  logic [REG_IDX_W-1:0]      rf_waddr,
  input  logic [XLEN-1:0]           rf_wdata,
  output logic [NUM_WATCH*XLEN-1:0] watch_vals,
  output logic                      chg_valid,
  output logic [IDX_W-1:0]          chg_idx,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          wr_count,
  output logic                      done,
  output logic                      halted,
  output logic                      timeout
);

  rw_state_e                        state_q, state_d;
  logic                             run;
  logic                             accepted;
  logic                             in_win;
  logic                             halt_hit;
  logic                             timeout_hit;
  logic [REG_IDX_W-1:0]             woff;
  logic [XLEN-1:0]                  pc_q;
  logic [NUM_WATCH-1:0][XLEN-1:0]   shadow_q;

  assign run         = (state_q == RW_RUN);
  assign accepted    = rf_we && (rf_waddr != '0);
  assign in_win      = (32'(rf_waddr) >= WATCH_BASE) &&
                       (32'(rf_waddr) <  WATCH_BASE + NUM_WATCH);
  assign woff        = rf_waddr - REG_IDX_W'(WATCH_BASE);
  assign timeout_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign watch_vals  = shadow_q;

  rv_halt_detect #(
    .XLEN        (XLEN),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .pc       (pc),
    .pc_q     (pc_q),
    .halt_hit (halt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= RW_RUN;
    else       state_q <= state_d;
  end

  // Halt takes priority when both terminal conditions land on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RW_RUN: begin
        if (halt_hit)         state_d = RW_HALT;
        else if (timeout_hit) state_d = RW_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= (state_d != RW_RUN);
      halted  <= (state_d == RW_HALT);
      timeout <= (state_d == RW_TIMEOUT);
    end
  end

  // Counters and shadows advance only while running; a write sampled on the
  // transition edge is still applied because state_q is RUN on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      wr_count    <= '0;
      chg_valid   <= 1'b0;
      chg_idx     <= '0;
      shadow_q    <= '0;
    end else begin
      chg_valid <= 1'b0;
      if (run) begin
        if (!timeout_hit) cycle_count <= cycle_count + CNT_W'(1);
        if (accepted) begin
          if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
          if (in_win) begin
            chg_valid <= 1'b1;
            chg_idx   <= IDX_W'(woff);
            for (int i = 0; i < int'(NUM_WATCH); i++) begin
              if (woff == REG_IDX_W'(i)) shadow_q[i] <= rf_wdata;
            end
          end
        end
      end
    end
  end

`ifdef RV_REGWATCH_TRACE_EN
  logic done_seen_q;

  always_ff @(posedge clk) begin
    if (reset) done_seen_q <= 1'b0;
    else       done_seen_q <= done;
    if (!reset && chg_valid) begin
      for (int i = 0; i < int'(NUM_WATCH); i++) begin
        if (IDX_W'(i) == chg_idx)
          $display("[%0t] regwatch pc=0x%08h x%0d <= 0x%08h",
                   $time, pc_q, WATCH_BASE + 32'(i), shadow_q[i]);
      end
    end
    if (!reset && done && !done_seen_q) begin
      $display("[%0t] regwatch %s cycles=%0d writes=%0d", $time,
               halted ? "HALT" : "TIMEOUT", cycle_count, wr_count);
      for (int i = 0; i < int'(NUM_WATCH); i++)
        $display("  x%0d = 0x%08h", WATCH_BASE + 32'(i), shadow_q[i]);
    end
  end
`else
  logic unused_pc_q;
  assign unused_pc_q = ^pc_q;
`endif

endmodule

// File: tb/tb_rv_regwatch_monitor.sv
// Self-checking bench for rv_regwatch_monitor: watched-write scoreboard plus
// per-scenario checks of counters, halt, timeout, tie and reset recovery.
module tb_rv_regwatch_monitor;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NW   = 3;
  localparam int unsigned WB   = 1;
  localparam int unsigned MAXC = 20;
  localparam int unsigned HR   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [XLEN-1:0]  pc = '0;
  logic             rf_we = 1'b0;
  logic [4:0]       rf_waddr = '0;
  logic [XLEN-1:0]  rf_wdata = '0;
  logic [NW*XLEN-1:0] watch_vals;
  logic             chg_valid;
  logic [1:0]       chg_idx;
  logic [31:0]      cycle_count;
  logic [31:0]      wr_count;
  logic             done, halted, timeout;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic        pc_run = 1'b0;
  logic [31:0] shadow_m [NW];
  int          exp_wr = 0;

  rv_regwatch_monitor #(
    .XLEN        (XLEN),
    .NUM_WATCH   (NW),
    .WATCH_BASE  (WB),
    .MAX_CYCLES  (MAXC),
    .HALT_REPEAT (HR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .watch_vals  (watch_vals),
    .chg_valid   (chg_valid),
    .chg_idx     (chg_idx),
    .cycle_count (cycle_count),
    .wr_count    (wr_count),
    .done        (done),
    .halted      (halted),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [NW*XLEN-1:0] model_vec();
    logic [NW*XLEN-1:0] v;
    for (int i = 0; i < int'(NW); i++) v[i*32 +: 32] = shadow_m[i];
    return v;
  endfunction

  // Pop the expected watched write whenever the DUT pulses chg_valid.
  always @(negedge clk) begin
    if (!reset && chg_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: chg_valid with idx=%0d, none expected", chg_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (chg_idx !== e.idx || watch_vals[32*int'(e.idx) +: 32] !== e.val) begin
          errors++;
          $display("FAIL sb_pulse: got idx=%0d val=0x%08h want idx=%0d val=0x%08h",
                   chg_idx, watch_vals[32*int'(e.idx) +: 32], e.idx, e.val);
        end
      end
    end
  end

  // Advance one cycle; outputs are then stable at the falling edge.
  task automatic step();
    @(negedge clk);
    if (pc_run) pc = pc + 32'd4;
  endtask

  // Drive one write for one edge and record its expected effects.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    if (a != 5'd0) exp_wr++;
    if (32'(a) >= WB && 32'(a) < WB + NW) begin
      sb.push_back('{idx: 2'(a - 5'(WB)), val: d});
      shadow_m[int'(a) - int'(WB)] = d;
    end
    step();
    rf_we = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; rf_we = 1'b0; pc_run = 1'b0; pc = '0;
    repeat (2) begin
      step();
      checks++;
      if (chg_valid !== 1'b0) begin
        errors++; $display("FAIL reset_chg: chg_valid=%b want 0", chg_valid);
      end
    end
    checks++;
    if ({watch_vals, chg_idx, cycle_count, wr_count, done, halted, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state: watch=%h idx=%0d cyc=%0d wr=%0d d/h/t=%b%b%b want all 0",
               watch_vals, chg_idx, cycle_count, wr_count, done, halted, timeout);
    end
    reset = 1'b0;
    sb.delete();
    exp_wr = 0;
    for (int i = 0; i < int'(NW); i++) shadow_m[i] = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    pc_run = 1'b1;
    step();
    checks++;
    if (cycle_count !== 32'd1 || done !== 1'b0) begin
      errors++; $display("FAIL reset_run: cyc=%0d done=%b want 1/0", cycle_count, done);
    end
  endtask

  task automatic test_watched_write();
    apply_reset();
    pc_run = 1'b1;
    wr(5'd2, 32'h0000_000A);
    checks++;
    if (watch_vals[63:32] !== 32'hA) begin
      errors++; $display("FAIL ww_slice: got 0x%08h want 0x0000000a", watch_vals[63:32]);
    end
    checks++;
    if (chg_valid !== 1'b1 || chg_idx !== 2'd1) begin
      errors++; $display("FAIL ww_pulse: valid=%b idx=%0d want 1/1", chg_valid, chg_idx);
    end
    checks++;
    if (wr_count !== 32'd1) begin
      errors++; $display("FAIL ww_count: got %0d want 1", wr_count);
    end
    step();
    checks++;
    if (chg_valid !== 1'b0) begin
      errors++; $display("FAIL ww_pulse_width: chg_valid=%b want 0", chg_valid);
    end
  endtask

  task automatic test_x0_outside();
    apply_reset();
    pc_run = 1'b1;
    wr(5'd2, 32'h0000_005A);
    wr(5'd0, 32'h0000_FFFF);
    checks++;
    if (wr_count !== 32'(exp_wr) || chg_valid !== 1'b0 || watch_vals !== model_vec()) begin
      errors++; $display("FAIL x0_write: wr=%0d valid=%b watch=%h want %0d/0/%h",
                         wr_count, chg_valid, watch_vals, exp_wr, model_vec());
    end
    wr(5'd7, 32'd5);
    checks++;
    if (wr_count !== 32'd2 || chg_valid !== 1'b0 || watch_vals !== model_vec()) begin
      errors++; $display("FAIL out_window: wr=%0d valid=%b watch=%h want 2/0/%h",
                         wr_count, chg_valid, watch_vals, model_vec());
    end
    rf_we = 1'b0; rf_waddr = 5'd1; rf_wdata = 32'hDEAD;
    step();
    checks++;
    if (wr_count !== 32'd2 || watch_vals !== model_vec()) begin
      errors++; $display("FAIL we_low: wr=%0d watch=%h want 2/%h",
                         wr_count, watch_vals, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [4] = '{5'd1, 5'd3, 5'd3, 5'd2};
    logic [31:0] datas [4] = '{32'h11, 32'h33, 32'h33, 32'h22};
    apply_reset();
    pc_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(addrs[i], datas[i]);
      checks++;
      if (chg_valid !== 1'b1 || watch_vals !== model_vec() || wr_count !== 32'(exp_wr)) begin
        errors++; $display("FAIL b2b_%0d: valid=%b watch=%h wr=%0d want 1/%h/%0d",
                           i, chg_valid, watch_vals, wr_count, model_vec(), exp_wr);
      end
    end
  endtask

  task automatic test_halt();
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      pc = 32'(4 * i);
      step();
    end
    repeat (2) begin
      step();
      checks++;
      if (halted !== 1'b0) begin
        errors++; $display("FAIL halt_early: halted=%b want 0", halted);
      end
    end
    wr(5'd9, 32'h99);
    checks++;
    if (halted !== 1'b1 || done !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL halt_flags: h/d/t=%b%b%b want 110", halted, done, timeout);
    end
    checks++;
    if (cycle_count !== 32'd13 || wr_count !== 32'd1) begin
      errors++; $display("FAIL halt_counts: cyc=%0d wr=%0d want 13/1", cycle_count, wr_count);
    end
    pc_run = 1'b1;
    rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = 32'h77;
    repeat (3) begin
      step();
      checks++;
      if (cycle_count !== 32'd13 || wr_count !== 32'd1 || watch_vals !== '0 ||
          chg_valid !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_freeze: cyc=%0d wr=%0d watch=%h valid=%b halted=%b",
                           cycle_count, wr_count, watch_vals, chg_valid, halted);
      end
    end
    rf_we = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    pc_run = 1'b1;
    repeat (19) step();
    checks++;
    if (cycle_count !== 32'd19 || timeout !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL to_early: cyc=%0d t=%b d=%b want 19/0/0", cycle_count, timeout, done);
    end
    step();
    checks++;
    if (timeout !== 1'b1 || done !== 1'b1 || halted !== 1'b0 || cycle_count !== 32'd19) begin
      errors++; $display("FAIL to_hit: t/d/h=%b%b%b cyc=%0d want 110/19",
                         timeout, done, halted, cycle_count);
    end
    rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = 32'h77;
    repeat (2) begin
      step();
      checks++;
      if (wr_count !== 32'd0 || watch_vals !== '0 || chg_valid !== 1'b0 || cycle_count !== 32'd19) begin
        errors++; $display("FAIL to_freeze: wr=%0d watch=%h valid=%b cyc=%0d",
                           wr_count, watch_vals, chg_valid, cycle_count);
      end
    end
    rf_we = 1'b0;
  endtask

  task automatic test_tie_recovery();
    apply_reset();
    pc_run = 1'b1;
    repeat (16) step();
    pc_run = 1'b0;
    repeat (3) step();
    checks++;
    if (halted !== 1'b0 || cycle_count !== 32'd19) begin
      errors++; $display("FAIL tie_pre: halted=%b cyc=%0d want 0/19", halted, cycle_count);
    end
    step();
    checks++;
    if (halted !== 1'b1 || timeout !== 1'b0 || done !== 1'b1 || cycle_count !== 32'd19) begin
      errors++; $display("FAIL tie_prio: h/t/d=%b%b%b cyc=%0d want 101/19",
                         halted, timeout, done, cycle_count);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({watch_vals, cycle_count, wr_count, done, halted, timeout, chg_valid} !== '0) begin
      errors++; $display("FAIL tie_reset: watch=%h cyc=%0d wr=%0d d/h/t/v=%b%b%b%b want all 0",
                         watch_vals, cycle_count, wr_count, done, halted, timeout, chg_valid);
    end
    reset = 1'b0;
    pc = 32'd100;
    pc_run = 1'b1;
    wr(5'd3, 32'h1234);
    checks++;
    if (chg_valid !== 1'b1 || chg_idx !== 2'd2 || wr_count !== 32'd1 || cycle_count !== 32'd1 ||
        done !== 1'b0 || watch_vals[95:64] !== 32'h1234) begin
      errors++; $display("FAIL tie_resume: valid=%b idx=%0d wr=%0d cyc=%0d done=%b x3=0x%08h",
                         chg_valid, chg_idx, wr_count, cycle_count, done, watch_vals[95:64]);
    end
  endtask

  initial begin
    test_reset();
    test_watched_write();
    test_x0_outside();
    test_back_to_back();
    test_halt();
    test_timeout();
    test_tie_recovery();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected pulses never seen", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
